// File: rtl/vectored_interrupt_controller.sv
// Purpose : fixed-priority interrupt controller that redirects CPU fetch to an ISR
//           vector, saves the interrupted PC and restores it on return (mret).
// Latency : request sampled on edge N -> vector on pc_next_final during cycle N+1;
//           saved PC on pc_next_final one cycle after mret is sampled in IN_ISR.
// Backpressure: none; no nesting, so requests are ignored while an ISR runs.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   irq_in         level-sensitive interrupt requests (NUM_IRQ)
//   irq_enable     per-line mask, 1 = enabled (NUM_IRQ)
//   global_ie      global interrupt enable
//   pc_next        next PC from normal fetch logic (PC_WIDTH)
//   mret           one-cycle return-from-ISR pulse
//   pc_next_final  PC loaded into the PC register (PC_WIDTH)
//   epc_out        saved return PC (registered)
//   cause_out      index of the serviced interrupt (registered, ID_W)
//   irq_ack        one-hot acknowledge, high only during ENTRY
//   in_isr         high in IN_ISR and RETURN
//
// Build option: define IRQ_VECTORED_EN for per-line vectors
// (ISR_BASE + cause*VECTOR_STRIDE); undefined = direct mode, every line jumps
// to ISR_BASE and software decodes cause_out.

module vectored_interrupt_controller #(
    parameter int          NUM_IRQ       = 8,
    parameter int          PC_WIDTH      = 32,
    parameter logic [31:0] ISR_BASE      = 32'h0000_0014,
    parameter int          VECTOR_STRIDE = 4,
    localparam int         ID_W          = $clog2(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  irq_enable,
    input  logic                global_ie,
    input  logic [PC_WIDTH-1:0] pc_next,
    input  logic                mret,
    output logic [PC_WIDTH-1:0] pc_next_final,
    output logic [PC_WIDTH-1:0] epc_out,
    output logic [ID_W-1:0]     cause_out,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic                in_isr
);

    // Elaboration-time parameter sanity checks.
    if (NUM_IRQ < 2 || NUM_IRQ > 32) begin : g_bad_num_irq
        $error("NUM_IRQ must be in 2..32");
    end
    if (VECTOR_STRIDE < 1) begin : g_bad_stride
        $error("VECTOR_STRIDE must be positive");
    end

    localparam logic [PC_WIDTH-1:0] BASE_PC = PC_WIDTH'(ISR_BASE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_IN_ISR = 2'd2,
        ST_RETURN = 2'd3
    } state_e;

    state_e              state_q;
    logic [PC_WIDTH-1:0] epc_q;
    logic [ID_W-1:0]     cause_q;

    logic [NUM_IRQ-1:0]  pending;
    logic [ID_W-1:0]     win_idx;
    logic                take_irq;
    logic [PC_WIDTH-1:0] vector_pc;

    assign pending  = irq_in & irq_enable;
    assign take_irq = global_ie && (pending != '0);

    // Lowest index wins: scan from the top so the last hit is the lowest one.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = ID_W'(i);
            end
        end
    end

`ifdef IRQ_VECTORED_EN
    // Arithmetic at PC_WIDTH so the target wraps modulo 2^PC_WIDTH.
    assign vector_pc = BASE_PC + (PC_WIDTH'(cause_q) * PC_WIDTH'(VECTOR_STRIDE));
`else
    assign vector_pc = BASE_PC;
`endif

    // State, saved PC and cause. epc/cause change only on IDLE->ENTRY, so a
    // request dropping after capture cannot disturb the entry in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_irq) begin
                        state_q <= ST_ENTRY;
                        epc_q   <= pc_next;
                        cause_q <= win_idx;
                    end
                end
                ST_ENTRY:  state_q <= ST_IN_ISR;
                // mret has priority; new requests are simply not looked at here.
                ST_IN_ISR: if (mret) state_q <= ST_RETURN;
                ST_RETURN: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state register.
    always_comb begin
        pc_next_final = pc_next;
        irq_ack       = '0;
        in_isr        = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                pc_next_final = vector_pc;
                irq_ack       = NUM_IRQ'(1) << cause_q;
            end
            ST_IN_ISR: in_isr = 1'b1;
            ST_RETURN: begin
                pc_next_final = epc_q;
                in_isr        = 1'b1;
            end
            default: ;
        endcase
    end

    assign epc_out   = epc_q;
    assign cause_out = cause_q;

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Purpose : self-checking bench for vectored_interrupt_controller (8 lines, 32-bit PC).
// Latency : entry checked one cycle after drive, return one cycle after mret.
// Backpressure: n/a; all waits are fixed cycle counts.

module tb_vectored_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic [7:0]  irq_enable;
    logic        global_ie;
    logic [31:0] pc_next;
    logic        mret;
    logic [31:0] pc_next_final;
    logic [31:0] epc_out;
    logic [2:0]  cause_out;
    logic [7:0]  irq_ack;
    logic        in_isr;

    int tests_run = 0;
    int tests_failed = 0;

    vectored_interrupt_controller dut (
        .clk           (clk),
        .reset         (rst_n),
        .irq_in        (irq_in),
        .irq_enable    (irq_enable),
        .global_ie     (global_ie),
        .pc_next       (pc_next),
        .mret          (mret),
        .pc_next_final (pc_next_final),
        .epc_out       (epc_out),
        .cause_out     (cause_out),
        .irq_ack       (irq_ack),
        .in_isr        (in_isr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  irq;
        logic [7:0]  en;
        logic        gie;
        logic [31:0] pc;
        logic        entry;
        logic [2:0]  cause;
    } vec_t;

    typedef struct {
        logic        entry;
        logic [2:0]  cause;
        logic [31:0] epc;
    } exp_t;

    vec_t tbl[7];
    exp_t sb[$];

    function automatic logic [31:0] vec_of(input logic [2:0] c);
`ifdef IRQ_VECTORED_EN
        return 32'h14 + 32'(c) * 32'd4;
`else
        return 32'h14 + 32'(c) * 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From ENTRY: drop the request, run one ISR cycle, return, land in IDLE.
    task automatic finish_isr(input logic [31:0] epc);
        irq_in  = 8'h00;
        pc_next = 32'h0000_0800;
        tick();
        chk("isr_in_isr", 32'(in_isr), 32'd1);
        chk("isr_ack0", 32'(irq_ack), 32'h0);
        chk("isr_pc", pc_next_final, 32'h800);
        mret = 1'b1;
        tick();
        chk("ret_pc", pc_next_final, epc);
        chk("ret_in_isr", 32'(in_isr), 32'd1);
        mret    = 1'b0;
        pc_next = 32'h0000_0900;
        tick();
        chk("idle_in_isr", 32'(in_isr), 32'd0);
        chk("idle_pc", pc_next_final, 32'h900);
        chk("idle_epc_hold", epc_out, epc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h04, 8'hFF, 1'b1, 32'h100, 1'b1, 3'd2};
        tbl[1] = '{8'hA0, 8'hFF, 1'b1, 32'h180, 1'b1, 3'd5};
        tbl[2] = '{8'h01, 8'hFE, 1'b1, 32'h1A0, 1'b0, 3'd0};
        tbl[3] = '{8'h02, 8'hFF, 1'b0, 32'h1C0, 1'b0, 3'd0};
        tbl[4] = '{8'h80, 8'hFF, 1'b1, 32'h1F0, 1'b1, 3'd7};
        tbl[5] = '{8'hFF, 8'hF0, 1'b1, 32'h2A0, 1'b1, 3'd4};
        tbl[6] = '{8'h03, 8'hFF, 1'b1, 32'h300, 1'b1, 3'd0};

        // Reset state
        rst_n = 1'b0; irq_in = '0; irq_enable = '0; global_ie = 1'b0;
        pc_next = 32'h200; mret = 1'b0;
        #1;
        chk("rst_pc", pc_next_final, 32'h200);
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_cause", 32'(cause_out), 32'h0);
        chk("rst_ack", 32'(irq_ack), 32'h0);
        chk("rst_in_isr", 32'(in_isr), 32'd0);
        tick();
        rst_n = 1'b1;
        pc_next = 32'h204;
        tick();
        chk("post_rst_pc", pc_next_final, 32'h204);
        chk("post_rst_in_isr", 32'(in_isr), 32'd0);

        // mret in IDLE is ignored
        mret = 1'b1;
        tick();
        chk("mret_idle_in_isr", 32'(in_isr), 32'd0);
        chk("mret_idle_pc", pc_next_final, 32'h204);
        mret = 1'b0;

        // Table-driven vectors
        foreach (tbl[r]) begin
            exp_t e;
            irq_in = tbl[r].irq; irq_enable = tbl[r].en;
            global_ie = tbl[r].gie; pc_next = tbl[r].pc;
            sb.push_back('{tbl[r].entry, tbl[r].cause, tbl[r].pc});
            tick();
            e = sb.pop_front();
            if (e.entry) begin
                chk($sformatf("v%0d_pc", r), pc_next_final, vec_of(e.cause));
                chk($sformatf("v%0d_ack", r), 32'(irq_ack), 32'(8'h01 << e.cause));
                chk($sformatf("v%0d_epc", r), epc_out, e.epc);
                chk($sformatf("v%0d_cause", r), 32'(cause_out), 32'(e.cause));
                chk($sformatf("v%0d_in_isr", r), 32'(in_isr), 32'd0);
                finish_isr(e.epc);
            end else begin
                for (int k = 0; k < 10; k++) begin
                    chk($sformatf("v%0d_noack", r), 32'(irq_ack), 32'h0);
                    chk($sformatf("v%0d_noisr", r), 32'(in_isr), 32'd0);
                    chk($sformatf("v%0d_pcpass", r), pc_next_final, tbl[r].pc);
                    tick();
                end
            end
            irq_in = 8'h00;
            tick();
        end
        irq_enable = 8'hFF; global_ie = 1'b1;

        // mret during ENTRY is ignored
        irq_in = 8'h08; pc_next = 32'h220;
        tick();
        chk("me_ack", 32'(irq_ack), 32'h08);
        mret = 1'b1; irq_in = 8'h00; pc_next = 32'h260;
        tick();
        chk("me_in_isr", 32'(in_isr), 32'd1);
        chk("me_pc", pc_next_final, 32'h260);
        mret = 1'b0;
        tick();
        chk("me_still_isr", 32'(in_isr), 32'd1);
        mret = 1'b1;
        tick();
        chk("me_ret_pc", pc_next_final, 32'h220);
        mret = 1'b0;
        tick();

        // Return has precedence over a simultaneous request, then re-entry
        irq_in = 8'h04; pc_next = 32'h100;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in = 8'h01; mret = 1'b1; pc_next = 32'h150;
        tick();
        chk("re_ret_pc", pc_next_final, 32'h100);
        chk("re_ret_ack", 32'(irq_ack), 32'h0);
        mret = 1'b0; pc_next = 32'h104;
        tick();
        chk("re_idle_pc", pc_next_final, 32'h104);
        chk("re_idle_ack", 32'(irq_ack), 32'h0);
        chk("re_idle_epc", epc_out, 32'h100);
        tick();
        chk("re_entry_pc", pc_next_final, vec_of(3'd0));
        chk("re_entry_cause", 32'(cause_out), 32'd0);
        chk("re_entry_ack", 32'(irq_ack), 32'h01);
        chk("re_entry_epc", epc_out, 32'h104);
        finish_isr(32'h104);

        // Reset in the middle of an ISR
        irq_in = 8'h02; pc_next = 32'h300;
        tick();
        irq_in = 8'h00;
        tick();
        chk("mr_in_isr_before", 32'(in_isr), 32'd1);
        pc_next = 32'h340;
        rst_n = 1'b0;
        #1;
        chk("mr_in_isr", 32'(in_isr), 32'd0);
        chk("mr_epc", epc_out, 32'h0);
        chk("mr_cause", 32'(cause_out), 32'h0);
        chk("mr_ack", 32'(irq_ack), 32'h0);
        chk("mr_pc", pc_next_final, 32'h340);
        @(posedge clk);
        #1;
        rst_n = 1'b1; pc_next = 32'h380;
        tick();
        chk("mr_after_pc", pc_next_final, 32'h380);
        chk("mr_after_in_isr", 32'(in_isr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vectored_interrupt_controller.md
Name: vectored_interrupt_controller

Overview:
- Parametrised multi-source interrupt controller for the CPU fetch path.
- Samples NUM_IRQ level-sensitive interrupt lines and applies a per-line mask and a global enable.
- Selects the highest-priority pending line, saves the interrupted PC, and redirects fetch to a per-line vector.
- Restores the saved PC when the core signals a return from the ISR. Sits between the PC-next logic and the PC register.

Parameters:
- NUM_IRQ, 8: number of interrupt lines, legal range 2..32. Derived localparam ID_W = $clog2(NUM_IRQ).
- PC_WIDTH, 32: width of every PC-carrying port.
- ISR_BASE, 32'h0000_0014: vector base address, truncated to PC_WIDTH.
- VECTOR_STRIDE, 4: byte distance between consecutive vectors.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  level-sensitive interrupt requests.
- irq_enable  in  NUM_IRQ  per-line mask; 1 = enabled.
- global_ie  in  1  global interrupt enable.
- pc_next  in  PC_WIDTH  next PC from the normal fetch logic.
- mret  in  1  one-cycle pulse marking a return from the ISR.
- pc_next_final  out  PC_WIDTH  PC that is actually loaded into the PC register.
- epc_out  out  PC_WIDTH  saved return PC.
- cause_out  out  ID_W  index of the interrupt being serviced.
- irq_ack  out  NUM_IRQ  one-hot acknowledge, asserted for one cycle.
- in_isr  out  1  high while the core is executing the ISR.

Behaviour:
- pending = irq_in & irq_enable. Priority is fixed: lowest index wins.
- State machine, 2-bit register: IDLE=0, ENTRY=1, IN_ISR=2, RETURN=3.
- IDLE
  - If global_ie=1 and pending!=0: go to ENTRY.
  - On that same edge: epc <= pc_next, cause <= winning index.
  - Otherwise stay in IDLE.
  - Output: pc_next_final = pc_next.
- ENTRY (exactly one cycle)
  - pc_next_final = vector target.
  - irq_ack = 1 << cause; irq_ack = 0 in every other state.
  - Unconditionally go to IN_ISR. mret is ignored here.
- IN_ISR
  - pc_next_final = pc_next; in_isr = 1.
  - No nesting: new or higher-priority requests are ignored.
  - If mret=1: go to RETURN.
- RETURN (exactly one cycle)
  - pc_next_final = epc; then go to IDLE.
  - in_isr = 1 in this state.
  - A request still pending is taken on the first IDLE cycle, so the earliest re-entry is 2 cycles after RETURN.
- Latency: an interrupt sampled on edge N gives the vector on pc_next_final during cycle N+1. The vector is combinational from state and cause.
- Vector arithmetic: ISR_BASE + cause*VECTOR_STRIDE, computed at PC_WIDTH and wrapping modulo 2^PC_WIDTH.
- mret in IDLE or ENTRY: ignored.
- mret and irq_in in the same IN_ISR cycle: the return has precedence.
- irq_in deasserting after capture does not abort the entry; cause and epc hold until the next capture.
- epc_out and cause_out are registered; they change only on an IDLE->ENTRY transition or on reset.
- Reset asserted (low) at any time, including mid-ISR:
  - Immediately: state=IDLE, epc_out=0, cause_out=0, in_isr=0, irq_ack=0.
  - pc_next_final = pc_next.
- The unused state encoding falls through to IDLE on the next edge.

Optional Feature:
- Macro IRQ_VECTORED_EN.
- Defined: target = ISR_BASE + cause*VECTOR_STRIDE.
- Undefined (direct mode):
  - Every interrupt jumps to ISR_BASE.
  - Software decodes the source from cause_out.
  - VECTOR_STRIDE is unused; the multiplier logic is not synthesised.
- All other behaviour is identical in both modes.

Test Plan:
- Reset low with pc_next=0x200 -> pc_next_final=0x200; epc_out=0, cause_out=0, irq_ack=0, in_isr=0. Release reset -> still IDLE.
- irq_enable=8'hFF, global_ie=1, irq_in=8'h04, pc_next=0x100 -> next cycle:
  - Vectored: pc_next_final=0x1C, irq_ack=8'h04, epc_out=0x100, cause_out=2.
  - Direct: pc_next_final=0x14.
  - Following cycle: in_isr=1.
- Priority: irq_in=8'hA0 -> cause_out=5, vector 0x28, irq_ack=8'h20.
- Masking:
  - irq_enable=8'hFE with irq_in=8'h01 -> stays IDLE, no irq_ack for 10 cycles.
  - global_ie=0 with irq_in=8'h02 -> no entry.
- Return and re-entry:
  - In IN_ISR, drive irq_in=8'h01 and mret=1 together -> RETURN, pc_next_final=0x100.
  - Next cycle IDLE with pc_next_final=pc_next; one cycle later ENTRY, vector 0x14, cause_out=0.
- Reset low for one cycle while in IN_ISR -> immediately in_isr=0, epc_out=0. After release, pc_next_final tracks pc_next.
